// File: rtl/vga_pixel_gen.sv
// VGA 640x480 pixel generator: turns the sync generator's pixel_X/pixel_Y
// into registered RGB. It supports four test patterns, and mode/colour
// updates are deferred to the frame boundary.
`timescale 1ns/1ps
module vga_pixel_gen #(
  parameter int HM       = 640,
  parameter int VM       = 480,
  parameter int BAR_W    = 80,
  parameter int BOX_X0   = 192,
  parameter int BOX_X1   = 447,
  parameter int BOX_Y0   = 112,
  parameter int BOX_Y1   = 367,
  parameter int CHK_LOG2 = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       p_tick,
  input  logic [9:0] pixel_X,
  input  logic [9:0] pixel_Y,
  input  logic       wr_req,
  input  logic [1:0] mode_in,
  input  logic [7:0] color_in,
  output logic       busy,
  output logic       wr_done,
  output logic       wr_err,
  output logic [7:0] rgb
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t     r_state;
  logic [1:0] r_mode, r_pend_mode;
  logic [7:0] r_color, r_pend_color;
  logic       r_busy, r_wr_done, r_wr_err;
  logic [7:0] r_rgb;

  logic       w_video_on, w_frame_bnd, w_in_box, w_chk_par;
  logic [2:0] w_bar_idx;
  logic [7:0] w_bar_rgb, w_pat;

  assign w_video_on  = (pixel_X < 10'(HM)) && (pixel_Y < 10'(VM));
  // First blanking line, first pixel: no visible pixel is being drawn here.
  assign w_frame_bnd = p_tick && (pixel_X == 10'd0) && (pixel_Y == 10'(VM));
  assign w_in_box    = (pixel_X >= 10'(BOX_X0)) && (pixel_X <= 10'(BOX_X1)) &&
                       (pixel_Y >= 10'(BOX_Y0)) && (pixel_Y <= 10'(BOX_Y1));
  assign w_chk_par   = pixel_X[CHK_LOG2] ^ pixel_Y[CHK_LOG2];

  // Bar index = pixel_X / BAR_W, done as a compare chain instead of a divider.
  always_comb begin
    w_bar_idx = 3'd0;
    for (int i = 1; i < 8; i++)
      if (pixel_X >= 10'(i * BAR_W)) w_bar_idx = 3'(i);
  end

  // Fixed colour-bar palette.
  always_comb begin
    w_bar_rgb = 8'h00;
    case (w_bar_idx)
      3'd0: w_bar_rgb = 8'hFF;
      3'd1: w_bar_rgb = 8'hFC;
      3'd2: w_bar_rgb = 8'h1F;
      3'd3: w_bar_rgb = 8'h1C;
      3'd4: w_bar_rgb = 8'hE3;
      3'd5: w_bar_rgb = 8'hE0;
      3'd6: w_bar_rgb = 8'h03;
      default: w_bar_rgb = 8'h00;
    endcase
  end

  // Pattern select from the active mode/colour.
  always_comb begin
    w_pat = r_color;
    case (r_mode)
      2'b00: w_pat = r_color;
      2'b01: w_pat = w_bar_rgb;
      2'b10: w_pat = w_in_box ? r_color : 8'h00;
      default: w_pat = w_chk_par ? ~r_color : r_color;
    endcase
  end

  // RGB register: loads every clock, so it stays aligned with the registered syncs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_rgb <= 8'h00;
    else       r_rgb <= w_video_on ? w_pat : 8'h00;
  end

  // Update handshake FSM: hold one request and apply it at the frame boundary.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_mode       <= 2'b00;
      r_color      <= 8'hFF;
      r_pend_mode  <= 2'b00;
      r_pend_color <= 8'h00;
      r_busy       <= 1'b0;
      r_wr_done    <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      r_wr_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (wr_req) begin
            r_pend_mode  <= mode_in;
            r_pend_color <= color_in;
            r_busy       <= 1'b1;
            r_state      <= PENDING;
          end
        end
        default: begin
          if (w_frame_bnd) begin
            r_mode    <= r_pend_mode;
            r_color   <= r_pend_color;
            r_wr_done <= 1'b1;
            if (wr_req) begin
              // Back-to-back request rides the boundary: it becomes the new pending value.
              r_pend_mode  <= mode_in;
              r_pend_color <= color_in;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else if (wr_req) begin
            r_wr_err <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign wr_done = r_wr_done;
  assign wr_err  = r_wr_err;
  assign rgb     = r_rgb;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Directed bench for vga_pixel_gen: pattern vectors from a table plus
// hand-written handshake sequences (error, coincident boundary, reset).
`timescale 1ns/1ps
module tb_vga_pixel_gen;

  logic       CLK = 0, RESET = 1, p_tick = 0, wr_req = 0;
  logic [9:0] pixel_X = 0, pixel_Y = 0;
  logic [1:0] mode_in = 0;
  logic [7:0] color_in = 0;
  logic       busy, wr_done, wr_err;
  logic [7:0] rgb;

  int checks = 0, failures = 0;

  vga_pixel_gen dut (
    .CLK(CLK), .RESET(RESET), .p_tick(p_tick), .pixel_X(pixel_X), .pixel_Y(pixel_Y),
    .wr_req(wr_req), .mode_in(mode_in), .color_in(color_in),
    .busy(busy), .wr_done(wr_done), .wr_err(wr_err), .rgb(rgb)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] color;
    logic [9:0] x, y;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Drive a pixel, then sample rgb just after the loading edge.
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [7:0] exp, input string name);
    @(negedge CLK);
    pixel_X = x; pixel_Y = y; p_tick = 0; wr_req = 0;
    @(posedge CLK); #1;
    chk(name, rgb, exp);
  endtask

  // One-cycle request at a visible pixel; busy must be set after the edge.
  task automatic request(input logic [1:0] m, input logic [7:0] c, input string name);
    @(negedge CLK);
    pixel_X = 10'd100; pixel_Y = 10'd10; p_tick = 0;
    wr_req = 1; mode_in = m; color_in = c;
    @(posedge CLK); #1;
    chk({name, "_busy"}, {7'd0, busy}, 8'd1);
    @(negedge CLK);
    wr_req = 0;
  endtask

  // Frame boundary cycle, optionally carrying a new request.
  task automatic boundary(input logic req, input logic [1:0] m, input logic [7:0] c,
                          input logic exp_done, input logic exp_busy, input string name);
    @(negedge CLK);
    pixel_X = 10'd0; pixel_Y = 10'd480; p_tick = 1;
    wr_req = req; mode_in = m; color_in = c;
    @(posedge CLK); #1;
    chk({name, "_done"}, {7'd0, wr_done}, {7'd0, exp_done});
    chk({name, "_busy"}, {7'd0, busy}, {7'd0, exp_busy});
    chk({name, "_err"},  {7'd0, wr_err}, 8'd0);
    @(negedge CLK);
    p_tick = 0; wr_req = 0; pixel_X = 10'd1;
    @(posedge CLK); #1;
    chk({name, "_done_clr"}, {7'd0, wr_done}, 8'd0);
  endtask

  initial begin
    logic [1:0] cur_mode;
    logic [7:0] cur_color;

    // mode 00 default colour FF
    vecs.push_back('{2'b00, 8'hFF, 10'd0,   10'd0,   8'hFF});
    vecs.push_back('{2'b00, 8'hFF, 10'd640, 10'd0,   8'h00});
    vecs.push_back('{2'b00, 8'hFF, 10'd0,   10'd480, 8'h00});
    vecs.push_back('{2'b00, 8'hFF, 10'd639, 10'd479, 8'hFF});
    // mode 01 bars, colour ignored
    vecs.push_back('{2'b01, 8'h55, 10'd85,  10'd0,   8'hFC});
    vecs.push_back('{2'b01, 8'h55, 10'd639, 10'd0,   8'h00});
    vecs.push_back('{2'b01, 8'h55, 10'd560, 10'd0,   8'h00});
    vecs.push_back('{2'b01, 8'h55, 10'd79,  10'd0,   8'hFF});
    vecs.push_back('{2'b01, 8'h55, 10'd80,  10'd0,   8'hFC});
    vecs.push_back('{2'b01, 8'h55, 10'd160, 10'd5,   8'h1F});
    vecs.push_back('{2'b01, 8'h55, 10'd240, 10'd0,   8'h1C});
    vecs.push_back('{2'b01, 8'h55, 10'd320, 10'd0,   8'hE3});
    vecs.push_back('{2'b01, 8'h55, 10'd400, 10'd0,   8'hE0});
    vecs.push_back('{2'b01, 8'h55, 10'd480, 10'd0,   8'h03});
    vecs.push_back('{2'b01, 8'h55, 10'd700, 10'd0,   8'h00});
    // mode 10 box
    vecs.push_back('{2'b10, 8'hE0, 10'd192, 10'd112, 8'hE0});
    vecs.push_back('{2'b10, 8'hE0, 10'd191, 10'd112, 8'h00});
    vecs.push_back('{2'b10, 8'hE0, 10'd447, 10'd367, 8'hE0});
    vecs.push_back('{2'b10, 8'hE0, 10'd448, 10'd367, 8'h00});
    vecs.push_back('{2'b10, 8'hE0, 10'd192, 10'd111, 8'h00});
    vecs.push_back('{2'b10, 8'hE0, 10'd300, 10'd368, 8'h00});
    // mode 11 checker
    vecs.push_back('{2'b11, 8'h1C, 10'd0,   10'd0,   8'h1C});
    vecs.push_back('{2'b11, 8'h1C, 10'd32,  10'd0,   8'hE3});
    vecs.push_back('{2'b11, 8'h1C, 10'd32,  10'd32,  8'h1C});
    vecs.push_back('{2'b11, 8'h1C, 10'd0,   10'd32,  8'hE3});
    vecs.push_back('{2'b11, 8'h1C, 10'd31,  10'd31,  8'h1C});

    // Reset state, checked while RESET is held.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rgb", rgb, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, wr_done}, 8'd0);
    chk("rst_err", {7'd0, wr_err}, 8'd0);
    @(negedge CLK);
    RESET = 0;

    // Request while video is on: old pattern must persist until the boundary.
    cur_mode = 2'b00; cur_color = 8'hFF;
    pix(10'd0, 10'd0, 8'hFF, "default_px0");
    request(2'b01, 8'h55, "req_bars");
    pix(10'd100, 10'd10, 8'hFF, "pending_unchanged");
    boundary(1'b0, 2'b00, 8'h00, 1'b1, 1'b0, "bnd_bars");
    boundary(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, "bnd_idle");
    request(2'b00, 8'hFF, "req_back");
    boundary(1'b0, 2'b00, 8'h00, 1'b1, 1'b0, "bnd_back");

    // Table sweep: reprogram whenever the vector's mode/colour changes.
    foreach (vecs[i]) begin
      if (vecs[i].mode != cur_mode || vecs[i].color != cur_color) begin
        request(vecs[i].mode, vecs[i].color, "tbl_req");
        boundary(1'b0, 2'b00, 8'h00, 1'b1, 1'b0, "tbl_bnd");
        cur_mode = vecs[i].mode; cur_color = vecs[i].color;
      end
      pix(vecs[i].x, vecs[i].y, vecs[i].exp, $sformatf("tbl%0d", i));
    end

    // Second request while busy: wr_err pulse, first value wins.
    request(2'b00, 8'h12, "err_first");
    @(negedge CLK);
    wr_req = 1; mode_in = 2'b00; color_in = 8'h34;
    @(posedge CLK); #1;
    chk("err_pulse", {7'd0, wr_err}, 8'd1);
    chk("err_busy", {7'd0, busy}, 8'd1);
    chk("err_nodone", {7'd0, wr_done}, 8'd0);
    @(negedge CLK);
    wr_req = 0;
    @(posedge CLK); #1;
    chk("err_clr", {7'd0, wr_err}, 8'd0);
    boundary(1'b0, 2'b00, 8'h00, 1'b1, 1'b0, "err_bnd");
    pix(10'd0, 10'd0, 8'h12, "err_applied_first");

    // Request coincident with boundary while pending.
    request(2'b00, 8'h56, "co_first");
    boundary(1'b1, 2'b00, 8'h78, 1'b1, 1'b1, "co_bnd");
    pix(10'd0, 10'd0, 8'h56, "co_old_applied");
    boundary(1'b0, 2'b00, 8'h00, 1'b1, 1'b0, "co_bnd2");
    pix(10'd0, 10'd0, 8'h78, "co_new_applied");

    // Request in IDLE on a boundary cycle: captured only.
    boundary(1'b1, 2'b00, 8'h9B, 1'b0, 1'b1, "idle_bnd_req");
    pix(10'd0, 10'd0, 8'h78, "idle_bnd_not_applied");
    boundary(1'b0, 2'b00, 8'h00, 1'b1, 1'b0, "idle_bnd_next");
    pix(10'd0, 10'd0, 8'h9B, "idle_bnd_applied");

    // Reset mid-pending: asynchronous clear, held request discarded.
    request(2'b10, 8'h9A, "rst_req");
    pix(10'd0, 10'd0, 8'h9B, "rst_pre");
    @(posedge CLK); #5;
    RESET = 1;
    #1;
    chk("arst_busy", {7'd0, busy}, 8'd0);
    chk("arst_rgb", rgb, 8'h00);
    @(negedge CLK);
    RESET = 0;
    boundary(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, "arst_bnd");
    pix(10'd0, 10'd0, 8'hFF, "arst_default");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Handshake pulses must never coincide.
  always @(negedge CLK) begin
    if (!RESET && wr_done && wr_err) begin
      checks++;
      failures++;
      $display("FAIL done_err_overlap: got both high expected at most one");
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
